// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper sequencer: drive modes, FSM states
// and the eight-entry coil phase table.
package stepper_pkg;

    localparam logic [1:0] MODE_WAVE = 2'b00;
    localparam logic [1:0] MODE_FULL = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;
    localparam logic [1:0] MODE_ALT  = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Coils {A,B,C,D}; element 0 is the least significant nibble
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    function automatic logic [3:0] phase_coils(input logic [2:0] idx);
        return PHASE_TABLE[idx];
    endfunction

endpackage

// File: rtl/stepper_rate_gen.sv
// Step-rate divider: one-cycle tick every max(period,1) clocks while enabled.
// A clear restarts the count so the first tick lands a full period later.
module stepper_rate_gen #(
    parameter int DIV_W = 24
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_period,
    output logic             o_tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] last;

    assign last   = (i_period == '0) ? '0 : i_period - DIV_W'(1);
    assign o_tick = i_en && !i_clear && (cnt_q == last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_clear || !i_en || o_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/stepper_sequencer.sv
// Stepper motor sequencer: walks the coil phase table in wave, full or
// half-step mode for a requested number of steps and tracks position.
module stepper_sequencer
    import stepper_pkg::*;
#(
    parameter int DIV_W = 24,
    parameter int POS_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [POS_W-1:0] i_steps,
    input  logic             i_dir,
    input  logic [1:0]       i_mode,
    input  logic [DIV_W-1:0] i_period,
    input  logic             i_abort,
    input  logic             i_hold,
    output logic [3:0]       o_coils,
    output logic             o_busy,
    output logic             o_done,
    output logic [POS_W-1:0] o_pos
);

    state_t           state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [POS_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic             done_d, done_q;
    logic [3:0]       coils_d, coils_q;
    logic             clear;
    logic             tick;
    logic [2:0]       step;

    stepper_rate_gen #(
        .DIV_W (DIV_W)
    ) u_rate (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (clear),
        .i_en     (state_q == S_RUN),
        .i_period (period_q),
        .o_tick   (tick)
    );

    assign step = (mode_q == MODE_HALF) ? 3'd1 : 3'd2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            phase_q  <= 3'd1;
            pos_q    <= '0;
            rem_q    <= '0;
            dir_q    <= 1'b0;
            mode_q   <= MODE_WAVE;
            period_q <= '0;
            done_q   <= 1'b0;
            coils_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            pos_q    <= pos_d;
            rem_q    <= rem_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            done_q   <= done_d;
            coils_q  <= coils_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        pos_d    = pos_q;
        rem_d    = rem_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        period_d = period_q;
        done_d   = 1'b0;
        clear    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    clear = 1'b1;
                    if (i_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = S_RUN;
                        rem_d    = i_steps;
                        dir_d    = i_dir;
                        mode_d   = i_mode;
                        period_d = i_period;
                        unique case (1'b1)
                            (i_mode == MODE_WAVE): phase_d[0] = 1'b0;
                            (i_mode == MODE_HALF): phase_d    = phase_q;
                            default:               phase_d[0] = 1'b1;
                        endcase
                    end
                end
            end
            S_RUN: begin
                // Abort wins over a tick landing in the same cycle
                if (i_abort) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    clear   = 1'b1;
                end else if (tick) begin
                    phase_d = dir_q ? phase_q + step : phase_q - step;
                    pos_d   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                    rem_d   = rem_q - POS_W'(1);
                    if (rem_q == POS_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase

        coils_d = (state_d == S_RUN || i_hold) ? phase_coils(phase_d) : 4'b0000;
    end

    assign o_coils = coils_q;
    assign o_busy  = (state_q == S_RUN);
    assign o_done  = done_q;
    assign o_pos   = pos_q;

endmodule

// File: tb/tb_stepper_sequencer.sv
// Self-checking bench for stepper_sequencer: a reference model pushes the
// expected coil/position per tick into a queue, popped as the DUT steps.
module tb_stepper_sequencer;

    localparam int DIV_W = 24;
    localparam int POS_W = 16;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_start;
    logic [POS_W-1:0] i_steps;
    logic             i_dir;
    logic [1:0]       i_mode;
    logic [DIV_W-1:0] i_period;
    logic             i_abort;
    logic             i_hold;
    logic [3:0]       o_coils;
    logic             o_busy;
    logic             o_done;
    logic [POS_W-1:0] o_pos;

    stepper_sequencer #(
        .DIV_W (DIV_W),
        .POS_W (POS_W)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (i_start),
        .i_steps  (i_steps),
        .i_dir    (i_dir),
        .i_mode   (i_mode),
        .i_period (i_period),
        .i_abort  (i_abort),
        .i_hold   (i_hold),
        .o_coils  (o_coils),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_pos    (o_pos)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int               cyc;
        logic [3:0]       coils;
        logic [POS_W-1:0] pos;
    } exp_t;

    exp_t             exp_q[$];
    int               n_pass = 0;
    int               n_total = 0;
    logic [2:0]       m_phase;
    logic [POS_W-1:0] m_pos;

    function automatic logic [3:0] ref_coils(input logic [2:0] p);
        case (p)
            3'd0: return 4'b1000;
            3'd1: return 4'b1100;
            3'd2: return 4'b0100;
            3'd3: return 4'b0110;
            3'd4: return 4'b0010;
            3'd5: return 4'b0011;
            3'd6: return 4'b0001;
            default: return 4'b1001;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        m_phase = 3'd1;
        m_pos   = '0;
    endtask

    // Drives one move; model predictions go to exp_q before the start edge
    task automatic test_move(input string name, input int steps, input bit dir,
                             input logic [1:0] mode, input int period,
                             input bit hold, input int abort_tick);
        int         p;
        int         nt;
        int         endc;
        int         early;
        logic [2:0] stp;
        logic [3:0] fin;
        exp_t       e;
        p = (period == 0) ? 1 : period;
        i_hold = hold;
        endc = 0;
        if (steps > 0) begin
            if (mode == 2'b00) m_phase[0] = 1'b0;
            else if (mode != 2'b10) m_phase[0] = 1'b1;
            stp = (mode == 2'b10) ? 3'd1 : 3'd2;
            nt = (abort_tick > 0) ? abort_tick - 1 : steps;
            for (int k = 1; k <= nt; k++) begin
                m_phase = dir ? m_phase + stp : m_phase - stp;
                m_pos   = dir ? m_pos + 1'b1 : m_pos - 1'b1;
                e.cyc   = k * p;
                e.coils = (k == steps && !hold) ? 4'b0000 : ref_coils(m_phase);
                e.pos   = m_pos;
                exp_q.push_back(e);
            end
            endc = (abort_tick > 0) ? abort_tick * p : steps * p;
        end
        fin = hold ? ref_coils(m_phase) : 4'b0000;
        @(negedge i_clk);
        i_start  = 1'b1;
        i_steps  = POS_W'(steps);
        i_dir    = dir;
        i_mode   = mode;
        i_period = DIV_W'(period);
        @(negedge i_clk);
        i_start  = 1'b0;
        i_steps  = POS_W'($urandom_range(1, 40));
        i_dir    = ~dir;
        i_mode   = 2'($urandom_range(0, 3));
        i_period = DIV_W'($urandom_range(5, 9));
        early = 0;
        for (int c = 0; c <= endc + 1; c++) begin
            if (c > 0) @(negedge i_clk);
            i_abort = (abort_tick > 0) && (c == abort_tick * p - 1);
            if (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                e = exp_q.pop_front();
                n_total++;
                if (o_coils !== e.coils)
                    $display("FAIL %s coils@%0d got %b want %b", name, c, o_coils, e.coils);
                else n_pass++;
                n_total++;
                if (o_pos !== e.pos)
                    $display("FAIL %s pos@%0d got %h want %h", name, c, o_pos, e.pos);
                else n_pass++;
            end
            if (c < endc) begin
                if (o_done !== 1'b0 || o_busy !== 1'b1) early++;
            end else if (c == endc) begin
                n_total++;
                if (o_done !== 1'b1)
                    $display("FAIL %s done_end got %b want 1", name, o_done);
                else n_pass++;
                n_total++;
                if (o_busy !== 1'b0)
                    $display("FAIL %s busy_end got %b want 0", name, o_busy);
                else n_pass++;
                n_total++;
                if (o_coils !== fin)
                    $display("FAIL %s coils_end got %b want %b", name, o_coils, fin);
                else n_pass++;
                n_total++;
                if (o_pos !== m_pos)
                    $display("FAIL %s pos_end got %h want %h", name, o_pos, m_pos);
                else n_pass++;
            end else begin
                n_total++;
                if (o_done !== 1'b0 || o_busy !== 1'b0)
                    $display("FAIL %s after_end done=%b busy=%b want 0 0", name, o_done, o_busy);
                else n_pass++;
            end
        end
        i_abort = 1'b0;
        n_total++;
        if (early != 0) $display("FAIL %s run_flags bad_cycles %0d want 0", name, early);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0)
            $display("FAIL %s missed_ticks got %0d want 0", name, exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset();
        i_rst_n  = 1'b0;
        i_start  = 1'b0;
        i_steps  = '0;
        i_dir    = 1'b0;
        i_mode   = 2'b00;
        i_period = '0;
        i_abort  = 1'b0;
        i_hold   = 1'b1;
        m_phase  = 3'd1;
        m_pos    = '0;
        #12;
        n_total++;
        if ({o_coils, o_busy, o_done} !== 6'b0 || o_pos !== '0)
            $display("FAIL reset_outputs got %b%b%b pos %h want 000000 pos 0", o_coils, o_busy, o_done, o_pos);
        else n_pass++;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        n_total++;
        if (o_coils !== 4'b1100)
            $display("FAIL reset_phase got %b want 1100", o_coils);
        else n_pass++;
    endtask

    task automatic test_full_fwd();
        test_move("full_fwd", 4, 1'b1, 2'b01, 3, 1'b1, 0);
        n_total++;
        if (o_pos !== 16'd4) $display("FAIL full_fwd pos got %h want 0004", o_pos);
        else n_pass++;
    endtask

    task automatic test_half_rev();
        do_reset();
        test_move("half_rev", 3, 1'b0, 2'b10, 1, 1'b0, 0);
        n_total++;
        if (o_pos !== 16'hFFFD) $display("FAIL half_rev pos got %h want fffd", o_pos);
        else n_pass++;
    endtask

    task automatic test_wave();
        do_reset();
        test_move("wave_align", 1, 1'b1, 2'b00, 2, 1'b1, 0);
        n_total++;
        if (o_coils !== 4'b0100) $display("FAIL wave_align coils got %b want 0100", o_coils);
        else n_pass++;
    endtask

    task automatic test_zero_steps();
        test_move("zero_hold", 0, 1'b1, 2'b01, 3, 1'b1, 0);
        test_move("zero_nohold", 0, 1'b0, 2'b10, 1, 1'b0, 0);
    endtask

    task automatic test_abort();
        do_reset();
        test_move("abort_hold", 5, 1'b1, 2'b01, 2, 1'b1, 2);
        n_total++;
        if (o_pos !== 16'd1) $display("FAIL abort_hold pos got %h want 0001", o_pos);
        else n_pass++;
        do_reset();
        test_move("abort_nohold", 5, 1'b1, 2'b01, 3, 1'b0, 2);
    endtask

    task automatic test_abort_idle();
        i_hold  = 1'b1;
        i_abort = 1'b1;
        repeat (3) @(negedge i_clk);
        n_total++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_pos !== m_pos || o_coils !== ref_coils(m_phase))
            $display("FAIL abort_idle busy=%b done=%b pos=%h coils=%b want 0 0 %h %b",
                     o_busy, o_done, o_pos, o_coils, m_pos, ref_coils(m_phase));
        else n_pass++;
        i_abort = 1'b0;
        i_hold  = 1'b0;
        @(negedge i_clk);
        n_total++;
        if (o_coils !== 4'b0000) $display("FAIL idle_release got %b want 0000", o_coils);
        else n_pass++;
    endtask

    task automatic test_period_zero();
        test_move("period_zero", 2, 1'b1, 2'b11, 0, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        test_move("b2b_first", 5, 1'b1, 2'b10, 2, 1'b1, 0);
        test_move("b2b_second", 3, 1'b0, 2'b00, 1, 1'b0, 0);
    endtask

    task automatic test_reset_mid_move();
        int pulses;
        i_hold = 1'b1;
        @(negedge i_clk);
        i_start  = 1'b1;
        i_steps  = POS_W'(10);
        i_dir    = 1'b1;
        i_mode   = 2'b01;
        i_period = DIV_W'(2);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (5) @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        n_total++;
        if ({o_coils, o_busy, o_done} !== 6'b0 || o_pos !== '0)
            $display("FAIL reset_mid got %b%b%b pos %h want 000000 pos 0", o_coils, o_busy, o_done, o_pos);
        else n_pass++;
        pulses = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        m_phase = 3'd1;
        m_pos   = '0;
        repeat (4) begin
            @(negedge i_clk);
            if (o_done !== 1'b0 || o_busy !== 1'b0) pulses++;
        end
        n_total++;
        if (pulses != 0) $display("FAIL reset_mid_flags got %0d want 0", pulses);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_fwd();
        test_half_rev();
        test_wave();
        test_zero_steps();
        test_abort();
        test_abort_idle();
        test_period_zero();
        test_back_to_back();
        test_reset_mid_move();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stepper_sequencer.md
STEPPER_SEQUENCER -- requirements
Module: stepper_sequencer

Interface
REQ-001 Parameter DIV_W, default 24, SHALL set the width of the step-period divider.
REQ-002 Parameter POS_W, default 16, SHALL set the width of the step-count and position values.
REQ-003 i_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 i_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_start  input  1  SHALL request a move; sampled only in IDLE.
REQ-006 i_steps  input  POS_W  SHALL give the number of steps to move, unsigned.
REQ-007 i_dir  input  1  SHALL give direction: 1 = forward (phase index increments), 0 = reverse.
REQ-008 i_mode  input  2  SHALL select the drive mode: 00 wave, 01 full, 10 half, 11 treated as full.
REQ-009 i_period  input  DIV_W  SHALL give clocks per step; 0 is treated as 1.
REQ-010 i_abort  input  1  SHALL stop a move in progress.
REQ-011 i_hold  input  1  SHALL keep coils energised in IDLE when 1.
REQ-012 o_coils  output  4  SHALL drive coils {A,B,C,D}, bit 3 = A.
REQ-013 o_busy  output  1  SHALL be high while in RUN.
REQ-014 o_done  output  1  SHALL be a one-cycle pulse at move completion or abort.
REQ-015 o_pos  output  POS_W  SHALL give the absolute position in steps, two's complement.

Function
REQ-016 Phase table, index 0..7, SHALL be: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
REQ-017 States SHALL be IDLE and RUN only; o_done is registered, not a state.
REQ-018 IDLE with i_start=1 SHALL latch i_steps, i_dir, i_mode and i_period; input changes during RUN are ignored.
REQ-019 Start with i_steps=0 SHALL stay in IDLE and pulse o_done on the next cycle, with no coil change.
REQ-020 Start with i_steps>0 SHALL enter RUN and align phase bit0: full forces 1, wave forces 0, half leaves it unchanged.
REQ-021 In RUN, a step tick SHALL occur every P clocks, P = max(latched period, 1); the first tick comes P cycles after the start edge.
REQ-022 On each tick, the phase index SHALL move by 1 in half mode or 2 otherwise, modulo 8, in the direction set by dir.
REQ-023 On each tick, o_pos SHALL change by +1 (forward) or -1 (reverse), wrapping modulo 2^POS_W.
REQ-024 On each tick, the remaining-steps count SHALL decrement.
REQ-025 On the tick where remaining steps reach 0, the block SHALL return to IDLE and pulse o_done in the same cycle o_busy falls.
REQ-026 i_abort in RUN SHALL force IDLE on the next edge, pulse o_done and suppress any tick in that cycle; abort has priority over a coincident tick.
REQ-027 i_abort in IDLE SHALL have no effect.
REQ-028 o_coils SHALL equal table[phase] in RUN, and in IDLE when i_hold=1.
REQ-029 o_coils SHALL be 0000 in IDLE when i_hold=0.
REQ-030 Phase index and o_pos SHALL be retained across moves.

Reset
REQ-031 Reset SHALL give: state IDLE, phase index 1, o_pos 0, o_coils 0000, o_busy 0, o_done 0, divider 0, remaining steps 0.
REQ-032 Reset asserted mid-move SHALL abandon the move immediately with no o_done pulse.

Structure
REQ-033 Package stepper_pkg SHALL hold the mode constants, the state enum and the 8-entry phase table.
REQ-034 Sub-module stepper_rate_gen SHALL produce the one-cycle tick from the latched period.
REQ-035 stepper_rate_gen SHALL be cleared on start and on abort.

Verification
REQ-036 Full mode, dir=1, steps=4, period=3, from reset: coils 0110, 0011, 1001, 1100 at cycles 3, 6, 9, 12 after start; o_done at cycle 12; o_pos=4.
REQ-037 Half mode, dir=0, steps=3, period=1, from phase 1: coils 1000, 1001, 0001; o_pos=-3 (0xFFFD).
REQ-038 Wave mode start from phase 1: phase aligns to 0, and the first tick with dir=1 gives 0100.
REQ-039 steps=0: o_done the next cycle, o_busy never high.
REQ-040 Abort coincident with the 2nd tick of a 5-step move: o_pos=1, o_done pulses, coils hold when i_hold=1, 0000 when i_hold=0.
REQ-041 Reset asserted mid-move: all outputs take their reset values asynchronously, with no o_done pulse.
